// File: rtl/fifo_flex_if.sv
// fifo_flex_if: handshake/data bundle between a fifo_flex and its user.
//   master : user side (drives clr, wr_en, din, rd_en; observes data/status)
//   slave  : FIFO side (observes requests; drives dout and all status)
// Signals:
//   clr          synchronous flush request
//   wr_en / din  write request and data (B bits)
//   rd_en        read request
//   dout         read data (B bits)
//   full, empty, almost_full, almost_empty   registered occupancy flags
//   count        words stored ($clog2(N+1) bits)
//   overflow, underflow                       sticky error flags
interface fifo_flex_if #(
   parameter int B = 16,
   parameter int N = 16
);
   logic                     clr;
   logic                     wr_en;
   logic [B-1:0]             din;
   logic                     rd_en;
   logic [B-1:0]             dout;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [$clog2(N+1)-1:0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output clr, wr_en, din, rd_en,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, din, rd_en,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO with arbitrary depth, selectable
// standard / first-word-fall-through read mode, programmable almost thresholds,
// occupancy count, sticky overflow/underflow flags and synchronous flush.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fifo_flex_if.slave (clr, wr_en, din, rd_en in; dout and status out)
// Parameters: B data width, N depth (>=2), FWFT read mode,
//             AF_TH almost-full threshold, AE_TH almost-empty threshold.
module fifo_flex #(
   parameter int B     = 16,
   parameter int N     = 16,
   parameter int FWFT  = 0,
   parameter int AF_TH = N - 2,
   parameter int AE_TH = 2
) (
   input  logic         clk,
   input  logic         rst,
   fifo_flex_if.slave   bus
);
   localparam int CW = $clog2(N + 1);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [B-1:0]  r_mem [N];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_af;
   logic          r_ae;
   logic          r_ov;
   logic          r_un;
   logic [B-1:0]  r_dout;

   logic          w_wr_acc;
   logic          w_rd_acc;
   logic [PW-1:0] w_wptr_nxt;
   logic [PW-1:0] w_rptr_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [B-1:0]  w_head_nxt;

   // Pointers wrap explicitly at N-1 so any depth works.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(N - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      // Acceptance uses registered flags only, so a same-cycle pop never
      // frees room for a write and a same-cycle push never feeds a read.
      w_wr_acc    = bus.wr_en && !r_full;
      w_rd_acc    = bus.rd_en && !r_empty;
      w_wptr_nxt  = w_wr_acc ? ptr_inc(r_wptr) : r_wptr;
      w_rptr_nxt  = w_rd_acc ? ptr_inc(r_rptr) : r_rptr;
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
      // Head word after this edge; when the word being written becomes the
      // head (FIFO empty after any pop) it is bypassed from din since the
      // memory write has not landed yet.
      w_head_nxt = (w_wr_acc && (w_rptr_nxt == r_wptr)) ? bus.din : r_mem[w_rptr_nxt];
   end

   // Storage is never reset.
   always_ff @(posedge clk) begin
      if (!rst && !bus.clr && w_wr_acc)
         r_mem[r_wptr] <= bus.din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ov    <= 1'b0;
         r_un    <= 1'b0;
         r_dout  <= '0;
      end else if (bus.clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ov    <= 1'b0;
         r_un    <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(N));
         r_empty <= (w_count_nxt == '0);
         r_af    <= (w_count_nxt >= CW'(AF_TH));
         r_ae    <= (w_count_nxt <= CW'(AE_TH));
         if (bus.wr_en && r_full)
            r_ov <= 1'b1;
         if (bus.rd_en && r_empty)
            r_un <= 1'b1;
         if (FWFT != 0) begin
            // Registered look-ahead of the head; holds last head when empty.
            if (w_count_nxt != '0)
               r_dout <= w_head_nxt;
         end else if (w_rd_acc) begin
            r_dout <= r_mem[r_rptr];
         end
      end
   end

   assign bus.dout         = r_dout;
   assign bus.count        = r_count;
   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_af;
   assign bus.almost_empty = r_ae;
   assign bus.overflow     = r_ov;
   assign bus.underflow    = r_un;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: three fifo_flex instances (N=5 standard, N=4 FWFT,
// N=8 standard with AF_TH=6/AE_TH=2) checked against a queue-based model.
module tb_fifo_flex;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   localparam int P_N  [3] = '{5, 4, 8};
   localparam int P_FW [3] = '{0, 1, 0};
   localparam int P_AF [3] = '{3, 2, 6};
   localparam int P_AE [3] = '{2, 1, 2};

   int n_chk = 0;
   int n_err = 0;

   logic       d_clr [3];
   logic       d_wr  [3];
   logic       d_rd  [3];
   logic [7:0] d_din [3];

   logic [7:0] o_dout [3];
   logic [3:0] o_cnt  [3];
   logic       o_full [3];
   logic       o_empty[3];
   logic       o_af   [3];
   logic       o_ae   [3];
   logic       o_ov   [3];
   logic       o_un   [3];

   fifo_flex_if #(.B(8), .N(5)) ifa ();
   fifo_flex_if #(.B(8), .N(4)) ifb ();
   fifo_flex_if #(.B(8), .N(8)) ifc ();

   fifo_flex #(.B(8), .N(5), .FWFT(0), .AF_TH(3), .AE_TH(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   fifo_flex #(.B(8), .N(4), .FWFT(1), .AF_TH(2), .AE_TH(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   fifo_flex #(.B(8), .N(8), .FWFT(0), .AF_TH(6), .AE_TH(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   assign ifa.clr = d_clr[0]; assign ifa.wr_en = d_wr[0]; assign ifa.rd_en = d_rd[0]; assign ifa.din = d_din[0];
   assign ifb.clr = d_clr[1]; assign ifb.wr_en = d_wr[1]; assign ifb.rd_en = d_rd[1]; assign ifb.din = d_din[1];
   assign ifc.clr = d_clr[2]; assign ifc.wr_en = d_wr[2]; assign ifc.rd_en = d_rd[2]; assign ifc.din = d_din[2];

   assign o_dout[0] = ifa.dout; assign o_cnt[0] = 4'(ifa.count); assign o_full[0] = ifa.full; assign o_empty[0] = ifa.empty;
   assign o_af[0] = ifa.almost_full; assign o_ae[0] = ifa.almost_empty; assign o_ov[0] = ifa.overflow; assign o_un[0] = ifa.underflow;
   assign o_dout[1] = ifb.dout; assign o_cnt[1] = 4'(ifb.count); assign o_full[1] = ifb.full; assign o_empty[1] = ifb.empty;
   assign o_af[1] = ifb.almost_full; assign o_ae[1] = ifb.almost_empty; assign o_ov[1] = ifb.overflow; assign o_un[1] = ifb.underflow;
   assign o_dout[2] = ifc.dout; assign o_cnt[2] = 4'(ifc.count); assign o_full[2] = ifc.full; assign o_empty[2] = ifc.empty;
   assign o_af[2] = ifc.almost_full; assign o_ae[2] = ifc.almost_empty; assign o_ov[2] = ifc.overflow; assign o_un[2] = ifc.underflow;

   // ---------------- reference model ----------------
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic       m_ov  [3];
   logic       m_un  [3];
   logic [7:0] m_dout[3];

   function automatic int msize(input int id);
      case (id)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [7:0] mhead(input int id);
      case (id)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic model_reset();
      q0.delete(); q1.delete(); q2.delete();
      for (int i = 0; i < 3; i++) begin
         m_ov[i] = 1'b0; m_un[i] = 1'b0; m_dout[i] = 8'h00;
      end
   endtask

   task automatic model_step(input int id, input logic c, input logic w, input logic [7:0] d, input logic r);
      int   sz;
      logic was_full;
      logic was_empty;
      logic [7:0] h;
      sz        = msize(id);
      was_full  = (sz == P_N[id]);
      was_empty = (sz == 0);
      if (c) begin
         case (id)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
         endcase
         m_ov[id] = 1'b0; m_un[id] = 1'b0; m_dout[id] = 8'h00;
         return;
      end
      if (w && was_full)  m_ov[id] = 1'b1;
      if (r && was_empty) m_un[id] = 1'b1;
      if (r && !was_empty) begin
         case (id)
            0: h = q0.pop_front();
            1: h = q1.pop_front();
            default: h = q2.pop_front();
         endcase
         if (P_FW[id] == 0) m_dout[id] = h;
      end
      if (w && !was_full) begin
         case (id)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
         endcase
      end
      if (P_FW[id] != 0 && msize(id) > 0) m_dout[id] = mhead(id);
   endtask

   // Drive one cycle on one instance; outputs are sampled 1 ns after the edge.
   task automatic step(input int id, input logic c, input logic w, input logic [7:0] d, input logic r);
      d_clr[id] = c; d_wr[id] = w; d_din[id] = d; d_rd[id] = r;
      @(posedge clk);
      model_step(id, c, w, d, r);
      #1;
      d_clr[id] = 1'b0; d_wr[id] = 1'b0; d_rd[id] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (o_dout[i] !== 8'h00 || o_cnt[i] !== 4'd0 || o_empty[i] !== 1'b1 || o_full[i] !== 1'b0 ||
             o_ae[i] !== 1'b1 || o_af[i] !== 1'b0 || o_ov[i] !== 1'b0 || o_un[i] !== 1'b0) begin
            n_err++;
            $display("FAIL reset[%0d]: dout=%h cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, required 00 0 1 0 1 0 0 0",
                     i, o_dout[i], o_cnt[i], o_empty[i], o_full[i], o_ae[i], o_af[i], o_ov[i], o_un[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 6; i++) step(0, 1'b0, 1'b1, 8'(i), 1'b0);
      n_chk++;
      if (o_full[0] !== 1'b1 || o_cnt[0] !== 4'd5 || o_ov[0] !== 1'b1) begin
         n_err++;
         $display("FAIL fill: full=%b cnt=%0d ov=%b, required 1 5 1", o_full[0], o_cnt[0], o_ov[0]);
      end
      for (int i = 1; i <= 5; i++) begin
         step(0, 1'b0, 1'b0, 8'h00, 1'b1);
         n_chk++;
         if (o_dout[0] !== 8'(i)) begin
            n_err++;
            $display("FAIL drain dout #%0d: got %h, required %h", i, o_dout[0], 8'(i));
         end
      end
      n_chk++;
      if (o_empty[0] !== 1'b1 || o_un[0] !== 1'b0) begin
         n_err++;
         $display("FAIL drain end: empty=%b un=%b, required 1 0", o_empty[0], o_un[0]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] prev;
      step(0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(0, 1'b0, 1'b1, 8'h10, 1'b0);
      prev = 8'h0F;
      for (int k = 0; k < 13; k++) begin
         step(0, 1'b0, 1'b1, 8'(8'h11 + k), 1'b1);
         n_chk++;
         if (o_dout[0] !== 8'(prev + 1) || o_cnt[0] !== 4'd1) begin
            n_err++;
            $display("FAIL wrap pair %0d: dout=%h cnt=%0d, required %h 1", k, o_dout[0], o_cnt[0], 8'(prev + 1));
         end
         prev = prev + 8'd1;
      end
   endtask

   task automatic test_empty_simul();
      step(0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(0, 1'b0, 1'b1, 8'h33, 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b1);
      step(0, 1'b0, 1'b1, 8'h44, 1'b1);
      n_chk++;
      if (o_cnt[0] !== 4'd1 || o_un[0] !== 1'b1 || o_dout[0] !== 8'h33 || o_ov[0] !== 1'b0) begin
         n_err++;
         $display("FAIL empty_simul: cnt=%0d un=%b dout=%h ov=%b, required 1 1 33 0", o_cnt[0], o_un[0], o_dout[0], o_ov[0]);
      end
   endtask

   task automatic test_fwft();
      step(1, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1, 1'b0, 1'b1, 8'hA5, 1'b0);
      n_chk++;
      if (o_dout[1] !== 8'hA5 || o_empty[1] !== 1'b0 || o_cnt[1] !== 4'd1) begin
         n_err++;
         $display("FAIL fwft write: dout=%h empty=%b cnt=%0d, required a5 0 1", o_dout[1], o_empty[1], o_cnt[1]);
      end
      step(1, 1'b0, 1'b0, 8'h00, 1'b1);
      n_chk++;
      if (o_empty[1] !== 1'b1 || o_cnt[1] !== 4'd0) begin
         n_err++;
         $display("FAIL fwft pop: empty=%b cnt=%0d, required 1 0", o_empty[1], o_cnt[1]);
      end
   endtask

   task automatic test_full_simul();
      step(1, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      n_chk++;
      if (o_full[1] !== 1'b1 || o_dout[1] !== 8'h50) begin
         n_err++;
         $display("FAIL full_simul fill: full=%b dout=%h, required 1 50", o_full[1], o_dout[1]);
      end
      step(1, 1'b0, 1'b1, 8'hEE, 1'b1);
      n_chk++;
      if (o_cnt[1] !== 4'd3 || o_ov[1] !== 1'b1 || o_full[1] !== 1'b0) begin
         n_err++;
         $display("FAIL full_simul: cnt=%0d ov=%b full=%b, required 3 1 0", o_cnt[1], o_ov[1], o_full[1]);
      end
      for (int k = 1; k <= 3; k++) begin
         n_chk++;
         if (o_dout[1] !== 8'(8'h50 + k)) begin
            n_err++;
            $display("FAIL full_simul head %0d: got %h, required %h", k, o_dout[1], 8'(8'h50 + k));
         end
         step(1, 1'b0, 1'b0, 8'h00, 1'b1);
      end
      n_chk++;
      if (o_empty[1] !== 1'b1 || o_un[1] !== 1'b0) begin
         n_err++;
         $display("FAIL full_simul drain: empty=%b un=%b, required 1 0", o_empty[1], o_un[1]);
      end
   endtask

   task automatic test_thresholds_flush();
      step(2, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         step(2, 1'b0, 1'b1, 8'(8'hC0 + c), 1'b0);
         if (c <= 8) begin
            n_chk++;
            if (o_ae[2] !== (c <= 2) || o_af[2] !== (c >= 6)) begin
               n_err++;
               $display("FAIL thresh cnt=%0d: ae=%b af=%b, required %b %b", c, o_ae[2], o_af[2], c <= 2, c >= 6);
            end
         end
      end
      step(2, 1'b0, 1'b0, 8'h00, 1'b1);
      n_chk++;
      if (o_ov[2] !== 1'b1 || o_dout[2] !== 8'hC1 || o_cnt[2] !== 4'd7) begin
         n_err++;
         $display("FAIL pre_flush: ov=%b dout=%h cnt=%0d, required 1 c1 7", o_ov[2], o_dout[2], o_cnt[2]);
      end
      step(2, 1'b1, 1'b1, 8'h77, 1'b0);
      n_chk++;
      if (o_cnt[2] !== 4'd0 || o_empty[2] !== 1'b1 || o_full[2] !== 1'b0 || o_ov[2] !== 1'b0 ||
          o_un[2] !== 1'b0 || o_dout[2] !== 8'h00 || o_ae[2] !== 1'b1 || o_af[2] !== 1'b0) begin
         n_err++;
         $display("FAIL flush: cnt=%0d e=%b f=%b ov=%b un=%b dout=%h ae=%b af=%b, required 0 1 0 0 0 00 1 0",
                  o_cnt[2], o_empty[2], o_full[2], o_ov[2], o_un[2], o_dout[2], o_ae[2], o_af[2]);
      end
   endtask

   task automatic test_random();
      int id;
      logic c, w, r;
      logic [7:0] d;
      int sz;
      for (int k = 0; k < 600; k++) begin
         id = int'($urandom_range(0, 2));
         c  = ($urandom_range(0, 59) == 0);
         if (((k / 40) % 2) == 0) begin
            w = ($urandom_range(0, 99) < 75);
            r = ($urandom_range(0, 99) < 35);
         end else begin
            w = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 75);
         end
         d = 8'($urandom);
         step(id, c, w, d, r);
         sz = msize(id);
         n_chk++;
         if (o_cnt[id] !== 4'(sz) || o_full[id] !== (sz == P_N[id]) || o_empty[id] !== (sz == 0) ||
             o_af[id] !== (sz >= P_AF[id]) || o_ae[id] !== (sz <= P_AE[id]) ||
             o_ov[id] !== m_ov[id] || o_un[id] !== m_un[id] ||
             ((P_FW[id] == 0 || sz > 0) && o_dout[id] !== m_dout[id])) begin
            n_err++;
            $display("FAIL random k=%0d id=%0d: cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b dout=%h, required cnt=%0d ov=%b un=%b dout=%h",
                     k, id, o_cnt[id], o_full[id], o_empty[id], o_af[id], o_ae[id], o_ov[id], o_un[id], o_dout[id],
                     sz, m_ov[id], m_un[id], m_dout[id]);
         end
      end
   endtask

   task automatic test_async_reset();
      step(2, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(2, 1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
      step(2, 1'b0, 1'b0, 8'h00, 1'b1);
      d_wr[2] = 1'b1; d_din[2] = 8'h9F;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (o_dout[i] !== 8'h00 || o_cnt[i] !== 4'd0 || o_empty[i] !== 1'b1 || o_full[i] !== 1'b0 ||
             o_ae[i] !== 1'b1 || o_af[i] !== 1'b0 || o_ov[i] !== 1'b0 || o_un[i] !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst[%0d]: dout=%h cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, required 00 0 1 0 1 0 0 0",
                     i, o_dout[i], o_cnt[i], o_empty[i], o_full[i], o_ae[i], o_af[i], o_ov[i], o_un[i]);
         end
      end
      d_wr[2] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(2, 1'b0, 1'b1, 8'h5A, 1'b0);
      step(2, 1'b0, 1'b0, 8'h00, 1'b1);
      n_chk++;
      if (o_dout[2] !== 8'h5A || o_empty[2] !== 1'b1) begin
         n_err++;
         $display("FAIL post_rst: dout=%h empty=%b, required 5a 1", o_dout[2], o_empty[2]);
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         d_clr[i] = 1'b0; d_wr[i] = 1'b0; d_rd[i] = 1'b0; d_din[i] = 8'h00;
      end
      model_reset();
      test_reset();
      test_fill_drain();
      test_wrap();
      test_empty_simul();
      test_fwft();
      test_full_simul();
      test_thresholds_flush();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the successor to the fixed-function `fifo`. It adds:
- arbitrary (non-power-of-two) depth,
- a selectable first-word-fall-through (FWFT) read mode,
- programmable almost-full/almost-empty thresholds,
- an occupancy count, sticky error flags and a synchronous flush.

It sits between signal-generator data producers and consumers in the same clock domain, as a drop-in replacement where flow-control margin or bypass latency matters.

## Interface
- `B`, 16, data width in bits (≥1)
- `N`, 16, depth in words (≥2, any integer)
- `FWFT`, 0, 0 = standard read mode, 1 = first-word-fall-through
- `AF_TH`, N-2, `almost_full` asserted when count ≥ AF_TH (1..N)
- `AE_TH`, 2, `almost_empty` asserted when count ≤ AE_TH (0..N-1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `clr`  in  1  synchronous flush
- `wr_en`  in  1  write request
- `din`  in  B  write data
- `rd_en`  in  1  read request
- `dout`  out  B  read data
- `full`  out  1  count == N
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AF_TH
- `almost_empty`  out  1  count ≤ AE_TH
- `count`  out  $clog2(N+1)  words stored
- `overflow`  out  1  sticky: write attempted while full
- `underflow`  out  1  sticky: read attempted while empty

## Operation
- Storage: N×B array; write pointer `wptr` and read pointer `rptr` count 0..N-1 and wrap N-1→0 explicitly. No modulo-2^k wrap.
- Accepted write:
  - Condition: wr_en && !full.
  - Action: mem[wptr] ← din, wptr advances.
- Accepted read:
  - Condition: rd_en && !empty.
  - Action: rptr advances.
- Flags use registered state only:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Count: +1 on write only, −1 on read only, unchanged on both or neither. Never exceeds N, never goes below 0.
- FWFT=0:
  - `dout` is a register, loaded with mem[rptr] on an accepted read.
  - `dout` holds its value otherwise, including on rejected reads.
- FWFT=1:
  - `dout` = mem[rptr] whenever !empty. Value is undefined-but-stable (last head) when empty.
  - rd_en pops the displayed word.
- Errors:
  - `overflow` sets on wr_en && full.
  - `underflow` sets on rd_en && empty.
  - Both are sticky until `clr` or `rst`.
- Flush (`clr`):
  - Pointers, count and both sticky flags go to 0; `dout` goes to 0.
  - Overrides wr_en/rd_en in the same cycle: nothing is written, no error is flagged.
- Memory contents are not reset.

## Timing
- Reset values:
  - `dout`=0, `count`=0, `empty`=1, `full`=0.
  - `almost_empty`=1 (AE_TH ≥ 0 always holds); `almost_full`=0.
  - `overflow`=0, `underflow`=0.
  - Pointers = 0.
- `rst` asserted mid-operation clears all state immediately, asynchronously. Release is synchronous to clk (synchronised externally).
- All status outputs are registered and reflect state after the last clock edge. A write at edge k gives `count`/`empty`/`full` updates visible after edge k.
- Read latency:
  - FWFT=0: data appears on `dout` one cycle after the accepted rd_en edge.
  - FWFT=1: `dout` is valid in the same cycle `empty` is low. A word written at edge k is on `dout` after edge k when the FIFO was empty.
- Throughput: one write and one read per cycle sustained.
  - Full: a simultaneous wr_en/rd_en accepts the read only; count goes N→N-1.
  - Empty: a simultaneous wr_en/rd_en accepts the write only; count goes 0→1.
- Error flags assert one cycle after the offending request.

## Test plan
- Fill/drain, B=8, N=5, FWFT=0:
  - Stimulus: write 0x01..0x05, then a 6th write 0x06; then 5 reads.
  - Required after the writes: full=1, count=5, overflow=1.
  - Required on reads: dout 0x01..0x05, each one cycle after its rd_en; empty=1 after the 5th.
- Non-power-of-two wrap, N=5:
  - Stimulus: 13 interleaved write/read pairs with incrementing data.
  - Required: dout sequence strictly incrementing across wptr/rptr wrap; count stays 1.
- FWFT=1:
  - Stimulus: write 0xA5 into empty.
  - Required: dout=0xA5 and empty=0 after the same edge.
  - Stimulus: rd_en for one cycle.
  - Required: empty=1 and count=0 after that edge.
- Full + simultaneous read/write, N=4:
  - Stimulus: wr_en=rd_en=1 while full.
  - Required: count=3, the written word is absent from later reads, overflow=1.
- Empty + simultaneous read/write:
  - Stimulus: wr_en=rd_en=1 while empty.
  - Required: count=1, underflow=1, dout unchanged (FWFT=0).
- Thresholds and flush, N=8, AF_TH=6, AE_TH=2:
  - Required: almost_empty drops at count=3; almost_full rises at count=6.
  - Stimulus: clr with wr_en=1.
  - Required: count=0, empty=1, flags 0, dout=0.
  - Stimulus: async rst mid-burst.
  - Required: all outputs at reset values before the next edge.
